// File: rtl/fiapp_mon_pkg.sv
// Shared types and MISR arithmetic for the fault-injection signature monitor.
// State encoding, signature width and the 16-bit MISR step function.
package fiapp_mon_pkg;

    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } mon_state_e;

    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic [2:0]       in3
    );
        return {sig[SIG_W-2:0], ^(sig & MISR_TAPS)}
             ^ {{(SIG_W-3){1'b0}}, in3};
    endfunction

endpackage

// File: rtl/fiapp_sig_monitor_misr.sv
// 16-bit MISR compressing the three app outputs, one step per enabled cycle.
// sig_next_o exposes the value that the next enabled edge will load.
module fiapp_misr16
    import fiapp_mon_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [2:0]       in_i,
    output logic [SIG_W-1:0] sig_o,
    output logic [SIG_W-1:0] sig_next_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    assign sig_d = misr_step(sig_q, in_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= '0;
        end else if (clear_i) begin
            sig_q <= '0;
        end else if (en_i) begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = sig_d;

endmodule

// File: rtl/fiapp_sig_monitor.sv
// Signature monitor: windowed MISR capture plus o2(t)==o1(t-1) invariant check.
// Optional golden compare enabled by FIAPP_SIG_MONITOR_GOLDEN_CMP_EN.
module fiapp_sig_monitor
    import fiapp_mon_pkg::*;
#(
    parameter int          WIN_LEN    = 32,
    parameter int          CNT_W      = 8,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             fi_o1,
    input  logic             fi_o2,
    input  logic             fi_o3,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             inv_err,
    output logic [CNT_W-1:0] inv_err_cnt,
    output logic             sig_match
);

    localparam int WCNT_W = $clog2(WIN_LEN + 1);
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    mon_state_e        state_q, state_d;
    logic [WCNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              o1_prev_q;
    logic              win_last;
    logic [SIG_W-1:0]  sig_next;

    assign win_last = (state_q == CAPTURE) && (win_q == WIN_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ARM;
            ARM:     state_d = CAPTURE;
            CAPTURE: if (win_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ARM) || (state_q == CAPTURE);
        done = (state_q == DONE);
    end

    // First capture cycle skips the check: o1_prev still holds the ARM-cycle o1.
    always_comb begin
        win_d = win_q;
        err_d = err_q;
        cnt_d = cnt_q;
        if (state_q == ARM) begin
            win_d = '0;
            err_d = 1'b0;
            cnt_d = '0;
        end else if (state_q == CAPTURE) begin
            win_d = win_q + WCNT_W'(1);
            if (win_q != '0 && fi_o2 != o1_prev_q) begin
                err_d = 1'b1;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            o1_prev_q <= 1'b0;
        end else begin
            win_q     <= win_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            o1_prev_q <= fi_o1;
        end
    end

    fiapp_misr16 u_misr (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q == ARM),
        .en_i       (state_q == CAPTURE),
        .in_i       ({fi_o3, fi_o2, fi_o1}),
        .sig_o      (signature),
        .sig_next_o (sig_next)
    );

    assign inv_err     = err_q;
    assign inv_err_cnt = cnt_q;

`ifdef FIAPP_SIG_MONITOR_GOLDEN_CMP_EN
    logic match_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b0;
        end else if (state_q == ARM) begin
            match_q <= 1'b0;
        end else if (win_last) begin
            match_q <= (sig_next == GOLDEN_SIG);
        end
    end

    assign sig_match = match_q;
`else
    logic unused_golden;
    assign unused_golden = ^{GOLDEN_SIG, sig_next};
    assign sig_match     = 1'b0;
`endif

endmodule

// File: tb/tb_fiapp_sig_monitor.sv
// Randomized self-checking bench for fiapp_sig_monitor with a windowed reference model.
// Instance a: WIN_LEN=4, CNT_W=8, GOLDEN 0011; instance b: WIN_LEN=8, CNT_W=2.
module tb_fiapp_sig_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        fi_o1 = 1'b0, fi_o2 = 1'b0, fi_o3 = 1'b0;
    logic        busy_a, done_a, err_a, match_a;
    logic [15:0] sig_a;
    logic [7:0]  cnt_a;
    logic        busy_b, done_b, err_b, match_b;
    logic [15:0] sig_b;
    logic [1:0]  cnt_b;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    fiapp_sig_monitor #(.WIN_LEN(4), .CNT_W(8), .GOLDEN_SIG(16'h0011)) u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .fi_o1(fi_o1), .fi_o2(fi_o2), .fi_o3(fi_o3),
        .busy(busy_a), .done(done_a), .signature(sig_a),
        .inv_err(err_a), .inv_err_cnt(cnt_a), .sig_match(match_a)
    );

    fiapp_sig_monitor #(.WIN_LEN(8), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .fi_o1(fi_o1), .fi_o2(fi_o2), .fi_o3(fi_o3),
        .busy(busy_b), .done(done_b), .signature(sig_b),
        .inv_err(err_b), .inv_err_cnt(cnt_b), .sig_match(match_b)
    );

    // Drives one full run on instance sel and computes expectations from the
    // recorded per-capture inputs. proto counts busy/done timing errors.
    task automatic run_window(
        input int sel, input bit rnd, input logic [2:0] fix, input bit poke,
        output logic [15:0] e_sig, output int e_cnt, output bit e_err,
        output bit e_match, output int proto
    );
        logic [2:0]  stim[$];
        logic [2:0]  v;
        logic [15:0] s;
        int          w, viol, cmax;
        logic        fb;
        w = sel ? 8 : 4;
        cmax = sel ? 3 : 255;
        proto = 0;
        @(negedge clk);
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        v = rnd ? 3'($urandom_range(0, 7)) : fix;
        {fi_o3, fi_o2, fi_o1} = v;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        if ((sel ? busy_b : busy_a) !== 1'b1) proto++;
        v = rnd ? 3'($urandom_range(0, 7)) : fix;
        {fi_o3, fi_o2, fi_o1} = v;
        @(negedge clk);
        for (int k = 0; k < w; k++) begin
            v = rnd ? 3'($urandom_range(0, 7)) : fix;
            {fi_o3, fi_o2, fi_o1} = v;
            stim.push_back(v);
            if (poke && k == 1) begin
                if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
            end
            if (poke && k == 2) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            @(negedge clk);
            if (k < w - 1 && ((sel ? done_b : done_a) !== 1'b0 ||
                              (sel ? busy_b : busy_a) !== 1'b1)) proto++;
        end
        if ((sel ? done_b : done_a) !== 1'b1 ||
            (sel ? busy_b : busy_a) !== 1'b0) proto++;
        s = 16'h0000;
        viol = 0;
        for (int i = 0; i < w; i++) begin
            fb = s[15] ^ s[13] ^ s[12] ^ s[10];
            s = {s[14:0], fb} ^ {13'b0, stim[i]};
            if (i > 0 && stim[i][1] != stim[i-1][0]) viol++;
        end
        e_sig = s;
        e_cnt = (viol > cmax) ? cmax : viol;
        e_err = (viol > 0);
`ifdef FIAPP_SIG_MONITOR_GOLDEN_CMP_EN
        e_match = (s == (sel ? 16'h0000 : 16'h0011));
`else
        e_match = 1'b0;
`endif
    endtask

    task automatic test_reset;
        @(negedge clk);
        total += 6;
        if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_a); end
        if (sig_a !== 16'h0) begin bad++; $display("FAIL reset_sig: got %h want 0000", sig_a); end
        if (err_a !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_a); end
        if (cnt_a !== 8'h0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
        if (match_a !== 1'b0) begin bad++; $display("FAIL reset_match: got %b want 0", match_a); end
        reset = 1'b0;
    endtask

    task automatic test_constant(input bit poke);
        logic [15:0] es; int ec, pr; bit ee, em;
        run_window(0, 1'b0, 3'b011, poke, es, ec, ee, em, pr);
        total += 6;
        if (pr != 0) begin bad++; $display("FAIL const_timing: got %0d errors want 0", pr); end
        if (sig_a !== 16'h0011) begin bad++; $display("FAIL const_sig: got %h want 0011", sig_a); end
        if (sig_a !== es) begin bad++; $display("FAIL const_sig_model: got %h want %h", sig_a, es); end
        if (err_a !== 1'b0) begin bad++; $display("FAIL const_err: got %b want 0", err_a); end
        if (cnt_a !== 8'd0) begin bad++; $display("FAIL const_cnt: got %0d want 0", cnt_a); end
        if (match_a !== em) begin bad++; $display("FAIL const_match: got %b want %b", match_a, em); end
        @(negedge clk);
        total += 2;
        if (done_a !== 1'b0) begin bad++; $display("FAIL const_done_pulse: got %b want 0", done_a); end
        if (sig_a !== 16'h0011) begin bad++; $display("FAIL const_hold: got %h want 0011", sig_a); end
    endtask

    task automatic test_violation;
        logic [15:0] es; int ec, pr; bit ee, em;
        run_window(0, 1'b0, 3'b001, 1'b0, es, ec, ee, em, pr);
        total += 5;
        if (pr != 0) begin bad++; $display("FAIL viol_timing: got %0d errors want 0", pr); end
        if (sig_a !== 16'h000F) begin bad++; $display("FAIL viol_sig: got %h want 000f", sig_a); end
        if (err_a !== 1'b1) begin bad++; $display("FAIL viol_err: got %b want 1", err_a); end
        if (cnt_a !== 8'd3) begin bad++; $display("FAIL viol_cnt: got %0d want 3", cnt_a); end
        if (match_a !== em) begin bad++; $display("FAIL viol_match: got %b want %b", match_a, em); end
    endtask

    task automatic test_saturation;
        logic [15:0] es; int ec, pr; bit ee, em;
        run_window(1, 1'b0, 3'b001, 1'b0, es, ec, ee, em, pr);
        total += 4;
        if (pr != 0) begin bad++; $display("FAIL sat_timing: got %0d errors want 0", pr); end
        if (cnt_b !== 2'd3) begin bad++; $display("FAIL sat_cnt: got %0d want 3", cnt_b); end
        if (err_b !== 1'b1) begin bad++; $display("FAIL sat_err: got %b want 1", err_b); end
        if (sig_b !== es) begin bad++; $display("FAIL sat_sig: got %h want %h", sig_b, es); end
    endtask

    task automatic test_random;
        logic [15:0] es; int ec, pr; bit ee, em;
        for (int r = 0; r < 10; r++) begin
            int sel;
            sel = (r % 3 == 2) ? 1 : 0;
            run_window(sel, 1'b1, 3'b000, 1'b0, es, ec, ee, em, pr);
            total += 5;
            if (pr != 0) begin bad++; $display("FAIL rnd%0d_timing: got %0d errors want 0", r, pr); end
            if ((sel ? sig_b : sig_a) !== es) begin
                bad++; $display("FAIL rnd%0d_sig: got %h want %h", r, sel ? sig_b : sig_a, es);
            end
            if ((sel ? err_b : err_a) !== ee) begin
                bad++; $display("FAIL rnd%0d_err: got %b want %b", r, sel ? err_b : err_a, ee);
            end
            if ((sel ? int'(cnt_b) : int'(cnt_a)) != ec) begin
                bad++; $display("FAIL rnd%0d_cnt: got %0d want %0d", r, sel ? int'(cnt_b) : int'(cnt_a), ec);
            end
            if ((sel ? match_b : match_a) !== em) begin
                bad++; $display("FAIL rnd%0d_match: got %b want %b", r, sel ? match_b : match_a, em);
            end
        end
    endtask

    task automatic test_start_busy;
        int dones;
        test_constant(1'b1);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) dones++;
        end
        total += 1;
        if (dones != 0) begin bad++; $display("FAIL busy_start_ignored: got %0d extra cycles want 0", dones); end
    endtask

    task automatic test_reset_midrun;
        int dones;
        @(negedge clk);
        start_a = 1'b1;
        {fi_o3, fi_o2, fi_o1} = 3'b011;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total += 1;
        if (sig_a !== 16'h0003) begin bad++; $display("FAIL mid_presig: got %h want 0003", sig_a); end
        reset = 1'b1;
        #1;
        total += 4;
        if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy_a); end
        if (sig_a !== 16'h0) begin bad++; $display("FAIL mid_sig: got %h want 0000", sig_a); end
        if (done_a !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", done_a); end
        if (cnt_a !== 8'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", cnt_a); end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) dones++;
        end
        total += 1;
        if (dones != 0) begin bad++; $display("FAIL mid_no_done: got %0d active cycles want 0", dones); end
        test_constant(1'b0);
    endtask

    initial begin
        test_reset();
        test_constant(1'b0);
        test_violation();
        test_saturation();
        test_random();
        test_start_busy();
        test_reset_midrun();
        test_constant(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
